baud_gen_multi: RTL and testbench
=================================

Name: baud_gen_multi

Overview:
- Parametrised successor to the fixed-rate UART baud generator. Derives three timing outputs from the system clock for one of four preset baud rates:
  - an oversampled receive tick,
  - a bit-rate transmit tick,
  - a 50% duty baud square wave.
- Sits between the system clock and the UART TX/RX cores. Also drives a debug divisor output.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD0, 2400, rate selected by baud_sel=0.
- BAUD1, 4800, rate selected by baud_sel=1.
- BAUD2, 9600, rate selected by baud_sel=2.
- BAUD3, 19200, rate selected by baud_sel=3.
- OVERSAMPLE, 16, rx ticks per bit; must be even and >=2.
- DIV_W, 16, width of the divisor and rx counter.
- ACC_W, 32, phase accumulator width; used only with FRAC_DIV_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run when high; freeze when low.
- baud_sel  in  2  preset rate select.
- rx_tick  out  1  one-cycle pulse, OVERSAMPLE per bit period.
- tx_tick  out  1  one-cycle pulse, once per bit period.
- baud_clk  out  1  square wave at the baud rate.
- div_value  out  DIV_W  active integer divisor, for debug.

Behaviour:
- Clocking: one clock (clock). Reset is asynchronous and active-high (reset). All outputs are registered.
- Divisor: Dn = (CLK_FREQ + BAUDn*OVERSAMPLE/2) / (BAUDn*OVERSAMPLE), i.e. rounded to nearest, computed at elaboration.
  - Elaboration fails if any Dn < 2 or Dn >= 2^DIV_W.
  - Elaboration fails if OVERSAMPLE is odd.
- Reset values:
  - rx_cnt=0, sub_cnt=0, sel_q=0.
  - rx_tick=0, tx_tick=0, baud_clk=0.
  - div_value=D0.
- rx counter:
  - rx_cnt counts 0..D-1.
  - rx_tick=1 for exactly one cycle, in the cycle after rx_cnt==D-1; rx_cnt wraps to 0 at that point.
  - Steady state: rx_tick period = D cycles.
  - First rx_tick comes D cycles after reset release or restart.
- Sub counter:
  - sub_cnt counts 0..OVERSAMPLE-1 and advances only on rx_tick.
  - tx_tick is asserted in the same cycle as the rx_tick that wraps sub_cnt from OVERSAMPLE-1 to 0.
  - tx_tick period = OVERSAMPLE*D cycles.
- baud_clk:
  - Registered; equals 1 while sub_cnt >= OVERSAMPLE/2, else 0.
  - Low in the first half of the bit period, high in the second half.
  - Falling edge coincides with tx_tick.
- enable low:
  - rx_cnt, sub_cnt and baud_clk hold their values.
  - rx_tick and tx_tick forced to 0.
  - On re-enable, counting resumes from the held value with no restart.
- Rate change:
  - sel_q samples baud_sel every cycle.
  - If baud_sel != sel_q: rx_cnt, sub_cnt and baud_clk are cleared, no tick is emitted that cycle, and div_value updates to the new Dn on the same edge.
  - Timing then follows the new rate from the restart, i.e. first rx_tick D_new cycles later.
  - A rate change while enable=0 still restarts the counters.
- Simultaneous rate change and rx wrap: the rate change wins; no tick is emitted.
- Reset mid-operation: all state clears immediately, asynchronously. Ticks drop in the same instant.

Optional Feature:
- Macro: FRAC_DIV_EN.
- Defined:
  - rx_cnt is replaced by an ACC_W-bit phase accumulator.
  - Increment INCn = round(BAUDn*OVERSAMPLE*2^ACC_W / CLK_FREQ).
  - rx_tick = registered carry-out of the accumulator.
  - Long-run rate error < 1 ppm; individual tick spacing jitters by at most 1 cycle.
  - The rate-change restart clears the accumulator.
  - div_value still reports the integer Dn.
- Undefined: integer divisor only, as described above; rate error is bounded by rounding of Dn.

Test Plan:
1. Reset held 100 ns, release, baud_sel=2, enable=1 -> rx_tick every 326 cycles; tx_tick every 5216 cycles; baud_clk high for 2608 cycles, low for 2608; div_value=326.
2. Sweep baud_sel 0,1,3 -> rx_tick periods 1302, 651 and 163 cycles; tx_tick periods 20832, 10416 and 2608 cycles.
3. Change baud_sel 2->3 at rx_cnt=200, sub_cnt=9 -> counters clear, baud_clk=0, no tick that cycle; first rx_tick 163 cycles later; first tx_tick 2608 cycles later.
4. Drop enable for 1000 cycles mid-bit -> no ticks while low; baud_clk holds; next rx_tick arrives (326 - cycles already elapsed in the current period) cycles after enable returns.
5. Assert reset asynchronously between clock edges while baud_clk=1 -> all outputs 0 immediately; div_value=1302 (D0).
6. With FRAC_DIV_EN and baud_sel=2 -> 1,000,000 cycles yield 3072 rx_tick pulses (+/-1); adjacent tick spacing is 325 or 326 cycles.

Source files
------------

// File: rtl/baud_gen_multi.sv
// baud_gen_multi: multi-rate UART baud generator.
// Derives an oversampled rx tick, a bit-rate tx tick and a 50% duty baud
// square wave from the system clock for one of four preset baud rates.
// Optional build macro FRAC_DIV_EN replaces the integer rx divider with a
// phase accumulator for sub-ppm long-run rate accuracy; div_value still
// reports the integer divisor in both builds.
module baud_gen_multi #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD0      = 2400,
   parameter int BAUD1      = 4800,
   parameter int BAUD2      = 9600,
   parameter int BAUD3      = 19200,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16,
   parameter int ACC_W      = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       baud_sel,
   output logic             rx_tick,
   output logic             tx_tick,
   output logic             baud_clk,
   output logic [DIV_W-1:0] div_value
);

   localparam int SUB_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

   // Integer divisor rounded to nearest: clocks per oversampled rx tick.
   function automatic longint calc_div(input longint baud);
      longint rate;
      rate = baud * longint'(OVERSAMPLE);
      return (longint'(CLK_FREQ) + rate / 2) / rate;
   endfunction

   function automatic bit div_ok(input longint d);
      return (d >= 2) && (d < (longint'(1) << DIV_W));
   endfunction

   localparam longint DIV0_L = calc_div(longint'(BAUD0));
   localparam longint DIV1_L = calc_div(longint'(BAUD1));
   localparam longint DIV2_L = calc_div(longint'(BAUD2));
   localparam longint DIV3_L = calc_div(longint'(BAUD3));

   localparam logic [DIV_W-1:0] DIV0 = DIV_W'(DIV0_L);
   localparam logic [DIV_W-1:0] DIV1 = DIV_W'(DIV1_L);
   localparam logic [DIV_W-1:0] DIV2 = DIV_W'(DIV2_L);
   localparam logic [DIV_W-1:0] DIV3 = DIV_W'(DIV3_L);

   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
   localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(OVERSAMPLE / 2);

   // Elaboration-time sanity: the square wave needs an even oversample
   // ratio, every divisor must fit the counter and be at least 2, and the
   // accumulator increment math is done in 64-bit arithmetic.
   if (OVERSAMPLE < 2 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
      $error("baud_gen_multi: OVERSAMPLE must be even and >= 2");
   end
   if (!div_ok(DIV0_L) || !div_ok(DIV1_L) || !div_ok(DIV2_L) || !div_ok(DIV3_L)) begin : g_bad_divisor
      $error("baud_gen_multi: a baud divisor is < 2 or does not fit DIV_W bits");
   end
   if (ACC_W < 2 || ACC_W > 40) begin : g_bad_acc_w
      $error("baud_gen_multi: ACC_W must be in 2..40");
   end

   logic [1:0]       sel_q;
   logic [DIV_W-1:0] div_new;
   logic [SUB_W-1:0] sub_cnt;
   logic [SUB_W-1:0] sub_inc;
   logic             rate_change;
   logic             rx_wrap;

   assign rate_change = (baud_sel != sel_q);
   assign sub_inc     = sub_cnt + 1'b1;

   // Divisor for the rate being requested right now, loaded on a rate change.
   always_comb begin
      div_new = DIV0;
      case (baud_sel)
         2'd0:    div_new = DIV0;
         2'd1:    div_new = DIV1;
         2'd2:    div_new = DIV2;
         default: div_new = DIV3;
      endcase
   end

`ifdef FRAC_DIV_EN
   // Phase increment per clock: BAUD*OVERSAMPLE*2^ACC_W / CLK_FREQ, rounded.
   function automatic longint calc_inc(input longint baud);
      longint num;
      num = (baud * longint'(OVERSAMPLE)) << ACC_W;
      return (num + longint'(CLK_FREQ) / 2) / longint'(CLK_FREQ);
   endfunction

   localparam logic [ACC_W-1:0] INC0 = ACC_W'(calc_inc(longint'(BAUD0)));
   localparam logic [ACC_W-1:0] INC1 = ACC_W'(calc_inc(longint'(BAUD1)));
   localparam logic [ACC_W-1:0] INC2 = ACC_W'(calc_inc(longint'(BAUD2)));
   localparam logic [ACC_W-1:0] INC3 = ACC_W'(calc_inc(longint'(BAUD3)));

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc_cur;
   logic [ACC_W:0]   acc_sum;

   // Accumulator carry-out marks an rx tick for the currently active rate.
   always_comb begin
      inc_cur = INC0;
      case (sel_q)
         2'd0:    inc_cur = INC0;
         2'd1:    inc_cur = INC1;
         2'd2:    inc_cur = INC2;
         default: inc_cur = INC3;
      endcase
      acc_sum = {1'b0, acc} + {1'b0, inc_cur};
      rx_wrap = acc_sum[ACC_W];
   end

   // Phase accumulator: restarts on a rate change, frozen while disabled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (rate_change) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc_sum[ACC_W-1:0];
      end
   end
`else
   logic [DIV_W-1:0] rx_cnt;

   assign rx_wrap = (rx_cnt == div_value - 1'b1);

   // Integer rx counter 0..D-1: restarts on a rate change, frozen while disabled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_cnt <= '0;
      end else if (rate_change) begin
         rx_cnt <= '0;
      end else if (enable) begin
         rx_cnt <= rx_wrap ? '0 : rx_cnt + 1'b1;
      end
   end
`endif

   // Rate tracking, sub-bit counter and registered tick/square-wave outputs;
   // a rate change takes priority over a coincident rx wrap.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sel_q     <= 2'd0;
         div_value <= DIV0;
         sub_cnt   <= '0;
         baud_clk  <= 1'b0;
         rx_tick   <= 1'b0;
         tx_tick   <= 1'b0;
      end else begin
         sel_q   <= baud_sel;
         rx_tick <= 1'b0;
         tx_tick <= 1'b0;
         if (rate_change) begin
            div_value <= div_new;
            sub_cnt   <= '0;
            baud_clk  <= 1'b0;
         end else if (enable && rx_wrap) begin
            rx_tick <= 1'b1;
            if (sub_cnt == SUB_LAST) begin
               sub_cnt  <= '0;
               tx_tick  <= 1'b1;
               baud_clk <= 1'b0;
            end else begin
               sub_cnt  <= sub_inc;
               baud_clk <= (sub_inc >= SUB_HALF);
            end
         end
      end
   end

endmodule

// File: tb/tb_baud_gen_multi.sv
// tb_baud_gen_multi: self-checking bench for baud_gen_multi (default build).
// Expected tick and baud_clk edge cycles are computed from the rate timeline
// and queued whenever stimulus is applied; a negedge monitor pops and
// compares them as the DUT produces (or fails to produce) events.
module tb_baud_gen_multi;

   localparam int OS = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  baud_sel;
   logic        rx_tick;
   logic        tx_tick;
   logic        baud_clk;
   logic [15:0] div_value;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   bit monEn = 1'b0;
   bit bclkPrev = 1'b0;

   int rxQ[$];
   int txQ[$];
   int bclkQ[$];

   baud_gen_multi dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .baud_sel  (baud_sel),
      .rx_tick   (rx_tick),
      .tx_tick   (tx_tick),
      .baud_clk  (baud_clk),
      .div_value (div_value)
   );

   // 50 MHz system clock
   always #10 clock = ~clock;

   // Count rising edges; outputs observed at a negedge reflect edge 'cyc'
   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input int got, input int want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] sel, input logic en);
      baud_sel = sel;
      enable   = en;
   endtask

   task automatic waitCyc(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   // baud_clk level expected after 'c - base' enabled cycles of a run
   function automatic int lvl(input int base, input int d, input int c);
      return ((((c - base) / d) % OS) >= OS / 2) ? 1 : 0;
   endfunction

   // Queue every event of a run restarted at 'base' with divisor d, limited
   // to the window lo <= cycle < hi
   task automatic pushRun(input int base, input int d, input int lo, input int hi);
      for (int k = 1; base + k * d < hi; k++) begin
         int c;
         c = base + k * d;
         if (c >= lo) begin
            rxQ.push_back(c);
            if (k % OS == 0) begin
               txQ.push_back(c);
               bclkQ.push_back(c);
            end else if (k % OS == OS / 2) begin
               bclkQ.push_back(c);
            end
         end
      end
   endtask

   // Scoreboard monitor: any tick or baud_clk edge, expected or not, is compared
   always @(negedge clock) begin : monitor
      bit rxExp, txExp, bExp, bChg;
      if (monEn) begin
         rxExp = (rxQ.size() > 0) && (rxQ[0] == cyc);
         txExp = (txQ.size() > 0) && (txQ[0] == cyc);
         bExp  = (bclkQ.size() > 0) && (bclkQ[0] == cyc);
         bChg  = (baud_clk != bclkPrev);
         if (rx_tick || rxExp)
            checkOutput("rx_tick_cycle", rx_tick ? cyc : -1,
                        rxExp ? cyc : ((rxQ.size() > 0) ? rxQ[0] : -1));
         if (tx_tick || txExp)
            checkOutput("tx_tick_cycle", tx_tick ? cyc : -1,
                        txExp ? cyc : ((txQ.size() > 0) ? txQ[0] : -1));
         if (bChg || bExp)
            checkOutput("baud_clk_edge", bChg ? cyc : -1,
                        bExp ? cyc : ((bclkQ.size() > 0) ? bclkQ[0] : -1));
         if (rxExp) void'(rxQ.pop_front());
         if (txExp) void'(txQ.pop_front());
         if (bExp)  void'(bclkQ.pop_front());
      end
      bclkPrev = baud_clk;
   end

   initial begin : stimulus
      int a, g, r2, r3, r4, e0, r5, eb;
      reset = 1'b1;
      applyStimulus(2'd0, 1'b0);

      // Reset state
      #95;
      checkOutput("reset_rx_tick", rx_tick, 0);
      checkOutput("reset_tx_tick", tx_tick, 0);
      checkOutput("reset_baud_clk", baud_clk, 0);
      checkOutput("reset_div", div_value, 1302);

      // Release with rate 2 selected: sel_q starts at 0, so the first edge restarts
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(2'd2, 1'b1);
      a = cyc + 1;
      g = a + 5216 + 10 * 326 + 50;
      pushRun(a, 326, a, g + 1);
      monEn = 1'b1;
      waitCyc(a);
      checkOutput("div_rate2", div_value, 326);

      // Enable low for 1000 cycles mid-bit (baud_clk high at that point)
      waitCyc(g);
      applyStimulus(2'd2, 1'b0);
      r2 = a + 1000 + 2 * 5216 + 9 * 326 + 201;
      pushRun(a + 1000, 326, g + 1001, r2);
      waitCyc(g + 500);
      checkOutput("bclk_hold_disabled", baud_clk, lvl(a, 326, g));
      waitCyc(g + 1000);
      applyStimulus(2'd2, 1'b1);

      // Rate 2 -> 3 at rx_cnt=200, sub_cnt=9
      waitCyc(r2 - 1);
      if (lvl(a + 1000, 326, r2 - 1) == 1) bclkQ.push_back(r2);
      applyStimulus(2'd3, 1'b1);
      r3 = r2 + 33 * 163;
      pushRun(r2, 163, r2, r3);
      waitCyc(r2);
      checkOutput("div_rate3", div_value, 163);
      checkOutput("bclk_cleared", baud_clk, 0);
      checkOutput("no_rx_on_change", rx_tick, 0);

      // Rate 3 -> 0 on the very edge where rx would wrap: change wins
      waitCyc(r3 - 1);
      if (lvl(r2, 163, r3 - 1) == 1) bclkQ.push_back(r3);
      applyStimulus(2'd0, 1'b1);
      r4 = r3 + 20832 + 1302 + 50;
      pushRun(r3, 1302, r3, r4);
      waitCyc(r3);
      checkOutput("div_rate0", div_value, 1302);
      checkOutput("no_rx_on_wrap_change", rx_tick, 0);

      // Rate 0 -> 1
      waitCyc(r4 - 1);
      if (lvl(r3, 1302, r4 - 1) == 1) bclkQ.push_back(r4);
      applyStimulus(2'd1, 1'b1);
      e0 = r4 + 2 * 10416 + 100;
      pushRun(r4, 651, r4, e0 + 1);
      waitCyc(r4);
      checkOutput("div_rate1", div_value, 651);

      // Rate change to 2 while disabled still restarts
      waitCyc(e0);
      applyStimulus(2'd1, 1'b0);
      waitCyc(e0 + 5);
      r5 = e0 + 6;
      if (lvl(r4, 651, e0) == 1) bclkQ.push_back(r5);
      applyStimulus(2'd2, 1'b0);
      eb = e0 + 20;
      pushRun(eb, 326, r5, eb + 2709);
      waitCyc(r5);
      checkOutput("div_change_disabled", div_value, 326);
      waitCyc(eb);
      applyStimulus(2'd2, 1'b1);

      // Async reset between edges while baud_clk is high
      waitCyc(eb + 2708);
      checkOutput("bclk_high_pre_reset", baud_clk, 1);
      @(negedge clock);
      monEn = 1'b0;
      checkOutput("rx_events_left", rxQ.size(), 0);
      checkOutput("tx_events_left", txQ.size(), 0);
      checkOutput("bclk_events_left", bclkQ.size(), 0);
      @(posedge clock);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("async_rx_tick", rx_tick, 0);
      checkOutput("async_tx_tick", tx_tick, 0);
      checkOutput("async_baud_clk", baud_clk, 0);
      checkOutput("async_div", div_value, 1302);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
